// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
// Purpose: FSM state encoding and bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach n-1, so $clog2(n) bits are enough (n >= 2).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/done handshake and operand/result bus
// Ports (master view): start, a, b, borrow_in out; ready, done, diff, borrow_out, ovf in.
interface serial_sub_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         ready;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  modport master (
    output start, a, b, borrow_in,
    input  ready, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b, borrow_in,
    output ready, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_sub_fs_cell.sv
// rtl/serial_sub_fs_cell.sv - combinational one-bit full subtractor
// Ports: a, b, bin in; d = a - b - bin (mod 2), bout = borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial ripple-borrow subtractor, LSB first
// Ports: clk, rst_n (async active-low); bus (slave): start/a/b/borrow_in in,
//        ready/done/diff/borrow_out/ovf out. diff = a - b - borrow_in mod 2^N.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sub_if.slave    bus
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    res_sr;
  logic            br;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    diff_q;
  logic            borrow_q;
  logic            ovf_q;
  logic            done_q;
  logic            d;
  logic            bout;

  fs_cell u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  assign bus.ready      = (state == IDLE);
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.ovf        = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.borrow_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= {d, res_sr[N-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= bout;
          if (cnt == LAST) begin
            // On the MSB step a_sr[0]/b_sr[0] hold the operand sign bits and d is
            // the result sign bit, so overflow needs no extra storage.
            diff_q   <= {d, res_sr[N-1:1]};
            borrow_q <= bout;
            ovf_q    <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking scoreboard bench for serial_sub
module tb_serial_sub;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] diff;
    logic         bo;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_sub_if #(.N(N)) bus ();

  serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    exp_t e;
    logic [N:0] full;
    full  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
    e.diff = full[N-1:0];
    e.bo   = full[N];
    e.ovf  = (a[N-1] != b[N-1]) && (e.diff[N-1] != a[N-1]);
    sb.push_back(e);
  endtask

  // Drives start for the accepting edge (edge 0); returns just after it.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.borrow_in = bi; bus.start = 1'b1;
    push_exp(a, b, bi);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Edges after edge 0 until done is seen; 0 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 3 * N; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow_out !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b diff=%h bo=%b ovf=%b, required 1 0 00 0 0",
               bus.ready, bus.done, bus.diff, bus.borrow_out, bus.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b required 1", bus.ready); end
  endtask

  task automatic test_basic;
    logic [N-1:0] va[8];
    logic [N-1:0] vb[8];
    logic         vi[8];
    exp_t e;
    int lat;
    va = '{8'h5A, 8'h00, 8'h80, 8'h10, 8'hFF, 8'h7F, 8'h00, 8'h00};
    vb = '{8'h3C, 8'h01, 8'h01, 8'h10, 8'hFF, 8'h80, 8'h00, 8'h00};
    vi = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 6; i < 8; i++) begin
      va[i] = N'($urandom); vb[i] = N'($urandom); vi[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.ready !== 1'b1) begin failures++; $display("FAIL basic_ready[%0d]: got %b required 1", i, bus.ready); end
      start_op(va[i], vb[i], vi[i]);
      checks++;
      if (bus.ready !== 1'b0) begin failures++; $display("FAIL basic_busy[%0d]: ready=%b required 0", i, bus.ready); end
      wait_done(lat);
      checks++;
      if (lat !== N) begin failures++; $display("FAIL basic_latency[%0d]: got %0d required %0d", i, lat, N); end
      e = sb.pop_front();
      checks++;
      if (bus.diff !== e.diff || bus.borrow_out !== e.bo || bus.ovf !== e.ovf) begin
        failures++;
        $display("FAIL basic_result[%0d] %h-%h-%b: diff=%h bo=%b ovf=%b required %h %b %b",
                 i, va[i], vb[i], vi[i], bus.diff, bus.borrow_out, bus.ovf, e.diff, e.bo, e.ovf);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.diff !== e.diff) begin
        failures++;
        $display("FAIL basic_hold[%0d]: done=%b diff=%h required 0 %h", i, bus.done, bus.diff, e.diff);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int ndone = 0;
    start_op(8'h05, 8'h03, 1'b0);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    e = sb.pop_front();
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
      if (k == N) begin
        checks++;
        if (bus.done !== 1'b1 || bus.diff !== e.diff || bus.borrow_out !== e.bo || bus.ovf !== e.ovf) begin
          failures++;
          $display("FAIL ignore_result: done=%b diff=%h bo=%b ovf=%b required 1 %h %b %b",
                   bus.done, bus.diff, bus.borrow_out, bus.ovf, e.diff, e.bo, e.ovf);
        end
      end
      if (k == N + 1) begin
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL ignore_done_width: done=%b required 0", bus.done); end
        bus.start = 1'b0;
      end
    end
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d required 1", ndone); end
    checks++;
    if (bus.ready !== 1'b1 || bus.diff !== 8'h02) begin
      failures++;
      $display("FAIL ignore_idle: ready=%b diff=%h required 1 02", bus.ready, bus.diff);
    end
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    int lat;
    int ndone = 0;
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== N || bus.diff !== e.diff || bus.borrow_out !== e.bo || bus.ovf !== e.ovf) begin
      failures++;
      $display("FAIL pre_reset_result: lat=%0d diff=%h bo=%b ovf=%b required %0d %h %b %b",
               lat, bus.diff, bus.borrow_out, bus.ovf, N, e.diff, e.bo, e.ovf);
    end
    @(posedge clk); #1;
    start_op(8'h77, 8'h11, 1'b0);
    void'(sb.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow_out !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: done=%b diff=%h bo=%b ovf=%b required 0 00 0 0",
               bus.done, bus.diff, bus.borrow_out, bus.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone !== 0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_abort: done_pulses=%0d ready=%b required 0 1", ndone, bus.ready);
    end
    start_op(8'h20, 8'h21, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== N || bus.diff !== e.diff || bus.borrow_out !== e.bo || bus.ovf !== e.ovf) begin
      failures++;
      $display("FAIL post_reset_result: lat=%0d diff=%h bo=%b ovf=%b required %0d %h %b %b",
               lat, bus.diff, bus.borrow_out, bus.ovf, N, e.diff, e.bo, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   t[$];
    @(negedge clk);
    bus.a = 8'hA5; bus.b = 8'h5B; bus.borrow_in = 1'b1; bus.start = 1'b1;
    repeat (3) push_exp(8'hA5, 8'h5B, 1'b1);
    for (int k = 0; k <= 45 && t.size() < 3; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        t.push_back(k);
        e = sb.pop_front();
        checks++;
        if (bus.diff !== e.diff || bus.borrow_out !== e.bo || bus.ovf !== e.ovf) begin
          failures++;
          $display("FAIL b2b_result[%0d]: diff=%h bo=%b ovf=%b required %h %b %b",
                   t.size(), bus.diff, bus.borrow_out, bus.ovf, e.diff, e.bo, e.ovf);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (t.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results required 3", t.size());
    end else begin
      checks++;
      if (t[0] !== N || t[1] - t[0] !== N + 2 || t[2] - t[1] !== N + 2) begin
        failures++;
        $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d required %0d %0d,%0d",
                 t[0], t[1] - t[0], t[2] - t[1], N, N + 2, N + 2);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_reset_midrun;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial ripple-borrow subtractor: the inverse of our parallel ripple-carry adder. It computes diff = a − b − borrow_in one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It trades N cycles of latency for minimal logic. It sits beside the adder in the datapath wherever area matters more than throughput, and is driven by a start/done handshake.

## Interface
- N, default 8, operand and result width in bits (N ≥ 2).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only while ready = 1.
- a  in  N  minuend; captured on the accepting edge.
- b  in  N  subtrahend; captured on the accepting edge.
- borrow_in  in  1  initial borrow; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; diff, borrow_out and ovf are valid from this cycle on.
- diff  out  N  a − b − borrow_in, modulo 2^N.
- borrow_out  out  1  1 when unsigned a < b + borrow_in.
- ovf  out  1  signed overflow: (a[N−1] ≠ b[N−1]) and (diff[N−1] ≠ a[N−1]).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at a clock edge: capture a, b, borrow_in into shift registers and the borrow flop, clear the bit counter, go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge processes bit i = counter value.
  - d = a_i ^ b_i ^ br.
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d shifts into the result register from the MSB side; the operand registers shift right.
  - The counter increments. On the edge that processes bit N−1, go to DONE.
- On that same edge: diff, borrow_out (the final br) and ovf load into the output registers.
- DONE: done = 1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- start is ignored outside IDLE, including during the DONE cycle. Operands are not re-sampled during RUN.
- diff, borrow_out and ovf hold their last result until the next completion. They do not change during RUN.
- Arithmetic is purely modular: no saturation, and no width extension of diff.
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE; the operation in flight is aborted with no done pulse.
  - Counter, shift registers, the borrow flop, diff, borrow_out, ovf and done all go to 0.
  - ready = 1 once rst_n is released.

## Timing
- Define edge 0 as the edge where start is accepted.
- Edges 1..N process bits 0..N−1.
- State is DONE after edge N, so done and valid outputs appear in the cycle after edge N.
- IDLE is re-entered at edge N+1. The earliest next accept is edge N+2.
- With start held at 1, one result is produced every N+2 cycles.
- ready is a decode of state (no extra latency): low from edge 0 until edge N+1.
- Counter width is $clog2(N). It never wraps inside an operation.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function returning the counter width for a given N.
- One sub-module, fs_cell: a combinational one-bit full subtractor with ports a, b, bin, d, bout. It is instantiated once in the top.
- Everything else (FSM, counter, shift registers, output registers) lives in serial_sub.

## Test plan
- a=8'h5A, b=8'h3C, borrow_in=0 → diff=8'h1E, borrow_out=0, ovf=0; done exactly 8 cycles after the accepting edge.
- a=8'h00, b=8'h01, borrow_in=0 → diff=8'hFF, borrow_out=1, ovf=0.
- a=8'h80, b=8'h01, borrow_in=0 → diff=8'h7F, borrow_out=0, ovf=1.
- a=8'h10, b=8'h10, borrow_in=1 → diff=8'hFF, borrow_out=1, ovf=0.
- Accept a=8'h05, b=8'h03; pulse start with a=8'hFF, b=8'h00 during RUN and during DONE → both ignored; diff=8'h02; exactly one done pulse.
- rst_n low while processing bit 4 → done stays 0; diff, borrow_out and ovf read 0; ready=1 after release. Next op a=8'h20, b=8'h21 → diff=8'hFF, borrow_out=1. Also check start held high continuously gives done every 10 cycles.
